adder_share_arb: RTL and testbench

ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

---
 rtl/adder_share_arb_pkg.sv | 7 +
 rtl/adder_share_arb_sat_add3.sv | 23 ++
 rtl/adder_share_arb.sv | 74 +++++++
 tb/tb_adder_share_arb.sv | 136 +++++++++++++
 4 files changed

// File: rtl/adder_share_arb_pkg.sv
// adder_share_arb_pkg: shared defaults and saturation limits for the shared adder
package adder_share_arb_pkg;
  localparam int DEF_W = 6;
  localparam int DEF_N = 4;
  localparam int SAT_MAX = 2**(DEF_W-1) - 1;
  localparam int SAT_MIN = -(2**(DEF_W-1));
endpackage

// File: rtl/adder_share_arb_sat_add3.sv
// sat_add3: combinational three-input two's complement saturating add; ports a, b, c in, sum clamped out, sat high when clamped
module sat_add3
  import adder_share_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic         sat
);
  logic [W+1:0] s;
  logic         pos;
  logic         neg;
  always_comb begin
    s   = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{2{c[W-1]}}, c};
    pos = !s[W+1] && (s[W:W-1] != 2'b00);
    neg = s[W+1] && (s[W:W-1] != 2'b11);
    sat = pos || neg;
    sum = pos ? {1'b0, {(W-1){1'b1}}} : neg ? {1'b1, {(W-1){1'b0}}} : s[W-1:0];
  end
endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one saturating 3-input adder among N requesters; req_* in, one-hot req_ready out, registered res_* out with valid/ready, sat_cnt counts clamped results (sat_clr clears)
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  parameter int TW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*W-1:0] req_c,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_sum,
  output logic [TW-1:0]  res_tag,
  output logic           res_sat,
  input  logic           sat_clr,
  output logic [15:0]    sat_cnt
);
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] gnt_idx;
  logic          gnt_any;
  logic          slot_free;
  logic          grant;
  logic [W-1:0]  sum;
  logic          sat;
  // Scan offsets from high to low so the nearest valid requester above rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (req_valid[(int'(rr_ptr) + j) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = TW'((int'(rr_ptr) + j) % N);
      end
    end
    slot_free = !res_valid || res_ready;
    grant     = gnt_any && slot_free && !rst;
    req_ready = grant ? N'(1) << gnt_idx : '0;
  end
  sat_add3 #(.W(W)) u_add (
    .a  (req_a[gnt_idx*W +: W]),
    .b  (req_b[gnt_idx*W +: W]),
    .c  (req_c[gnt_idx*W +: W]),
    .sum(sum),
    .sat(sat)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_tag   <= '0;
      res_sat   <= 1'b0;
      sat_cnt   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (grant) begin
        res_valid <= 1'b1;
        res_sum   <= sum;
        res_tag   <= gnt_idx;
        res_sat   <= sat;
        rr_ptr    <= TW'((int'(gnt_idx) + 1) % N);
      end else if (slot_free) begin
        res_valid <= 1'b0;
      end
      if (sat_clr) sat_cnt <= '0;
      else if (grant && sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed vector table plus hand sequences for the shared saturating adder
module tb_adder_share_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_a, req_b, req_c;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_sum;
  logic [1:0]  res_tag;
  logic        res_sat;
  logic        sat_clr;
  logic [15:0] sat_cnt;
  int total = 0;
  int bad = 0;
  typedef struct {
    int         idx;
    logic [5:0] a, b, c, sum;
    logic       sat;
  } vec_t;
  vec_t vec [10];
  adder_share_arb #(.W(6), .N(4), .TW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_tag(res_tag), .res_sat(res_sat),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec[0] = '{2, 6'd10, -6'sd3, 6'd5, 6'd12, 1'b0};
    vec[1] = '{0, 6'd31, 6'd31, 6'd31, 6'd31, 1'b1};
    vec[2] = '{3, -6'sd32, -6'sd32, -6'sd32, -6'sd32, 1'b1};
    vec[3] = '{1, 6'd20, 6'd15, -6'sd4, 6'd31, 1'b0};
    vec[4] = '{1, 6'd20, 6'd15, -6'sd3, 6'd31, 1'b1};
    vec[5] = '{0, -6'sd20, -6'sd10, -6'sd2, -6'sd32, 1'b0};
    vec[6] = '{2, -6'sd20, -6'sd10, -6'sd3, -6'sd32, 1'b1};
    vec[7] = '{3, 6'd31, -6'sd32, 6'd0, -6'sd1, 1'b0};
    vec[8] = '{0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0};
    vec[9] = '{1, -6'sd1, -6'sd1, -6'sd1, -6'sd3, 1'b0};
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    res_ready = 1'b1; sat_clr = 1'b0;
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_cnt", sat_cnt, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 4'b1 << vec[i].idx;
      req_a = '0; req_b = '0; req_c = '0;
      req_a[vec[i].idx*6 +: 6] = vec[i].a;
      req_b[vec[i].idx*6 +: 6] = vec[i].b;
      req_c[vec[i].idx*6 +: 6] = vec[i].c;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, 4'b1 << vec[i].idx);
      tick();
      chk($sformatf("v%0d_valid", i), res_valid, 1);
      chk($sformatf("v%0d_sum", i), res_sum, vec[i].sum);
      chk($sformatf("v%0d_tag", i), res_tag, vec[i].idx);
      chk($sformatf("v%0d_sat", i), res_sat, vec[i].sat);
    end
    chk("tbl_cnt", sat_cnt, 4);
    // reset with a held result, then all four requesting: must start from 0 although rr_ptr was 2
    rst = 1'b1;
    req_valid = 4'hF;
    req_a = {6'd4, 6'd3, 6'd2, 6'd1}; req_b = '0; req_c = '0;
    #1;
    chk("mrst_valid", res_valid, 0);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_cnt", sat_cnt, 0);
    chk("mrst_tag", res_tag, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), req_ready, 4'b1 << (k % 4));
      tick();
      chk($sformatf("rr%0d_valid", k), res_valid, 1);
      chk($sformatf("rr%0d_tag", k), res_tag, k % 4);
      chk($sformatf("rr%0d_sum", k), res_sum, k % 4 + 1);
    end
    // backpressure: held result, no grant until the consumer is ready
    res_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[6 +: 6] = 6'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_ready", k), req_ready, 0);
      tick();
      chk($sformatf("hold%0d_valid", k), res_valid, 1);
      chk($sformatf("hold%0d_sum", k), res_sum, 1);
      chk($sformatf("hold%0d_tag", k), res_tag, 0);
    end
    res_ready = 1'b1;
    #1;
    chk("rel_ready", req_ready, 4'b0010);
    tick();
    chk("rel_tag", res_tag, 1);
    chk("rel_sum", res_sum, 7);
    req_valid = '0;
    tick();
    chk("drain_valid", res_valid, 0);
    // saturation counter: clear priority and sticking at the maximum
    req_valid = 4'b0001;
    req_a[0 +: 6] = 6'd31; req_b[0 +: 6] = 6'd31; req_c[0 +: 6] = 6'd31;
    tick();
    tick();
    chk("sat_cnt2", sat_cnt, 2);
    chk("sat_sum", res_sum, 31);
    chk("sat_flag", res_sat, 1);
    sat_clr = 1'b1;
    tick();
    chk("clr_prio", sat_cnt, 0);
    sat_clr = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_max", sat_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_stick", sat_cnt, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
